// File: rtl/retro_bram_arbiter.sv
// Shares one single-port byte-write BRAM among several requesters using
// round-robin arbitration with a priority mask and a starvation guard.
module retro_bram_arbiter #(
   parameter int                       NumRequesters   = 4,
   parameter int                       AddressBusWidth = 12,
   parameter int                       DataBusWidth    = 1,
   parameter logic [NumRequesters-1:0] PriorityMask    = 4'b0001,
   parameter int                       MaxWait         = 7
) (
   input  logic                                       clk_i,
   input  logic                                       reset_i,
   input  logic [NumRequesters-1:0]                   reqAccess_i,
   input  logic [NumRequesters*DataBusWidth-1:0]      reqWrite_i,
   input  logic [NumRequesters*AddressBusWidth-1:0]   reqAddress_i,
   input  logic [NumRequesters*8*DataBusWidth-1:0]    reqDin_i,
   output logic [NumRequesters-1:0]                   reqReady_o,
   output logic [NumRequesters-1:0]                   reqDataReady_o,
   output logic [8*DataBusWidth-1:0]                  reqDout_o,
   output logic                                       memAccess_o,
   output logic [DataBusWidth-1:0]                    memWrite_o,
   output logic [AddressBusWidth-1:0]                 memAddress_o,
   output logic [8*DataBusWidth-1:0]                  memDin_o,
   input  logic [8*DataBusWidth-1:0]                  memDout_i
);

   localparam int IdxW  = $clog2(NumRequesters);
   localparam int WaitW = 8;
   localparam int DinW  = 8 * DataBusWidth;
   localparam logic [WaitW-1:0] MaxWaitC = WaitW'(MaxWait);

   logic [IdxW-1:0]            rrPointer_q, rrPointer_d;
   logic [WaitW-1:0]           waitCount_q [NumRequesters];
   logic [WaitW-1:0]           waitCount_d [NumRequesters];
   logic                       pendRead_q, pendRead_d;
   logic [IdxW-1:0]            pendIndex_q, pendIndex_d;
   logic [DinW-1:0]            doutHold_q, doutHold_d;
   logic [AddressBusWidth-1:0] addrHold_q, addrHold_d;
   logic [DinW-1:0]            dinHold_q, dinHold_d;

   logic                       starvedHit, prioHit, rrHit, grantValid;
   logic [IdxW-1:0]            starvedIdx, prioIdx, rrIdx, rrCand, winner;
   logic [DataBusWidth-1:0]    winWrite;
   logic [AddressBusWidth-1:0] winAddress;
   logic [DinW-1:0]            winDin;

   // Three candidate searches; descending loops leave the preferred index last.
   always_comb begin
      starvedHit = 1'b0;
      starvedIdx = '0;
      prioHit    = 1'b0;
      prioIdx    = '0;
      rrHit      = 1'b0;
      rrIdx      = '0;
      rrCand     = '0;
      for (int i = NumRequesters - 1; i >= 0; i--) begin
         if (reqAccess_i[i] && waitCount_q[i] == MaxWaitC) begin
            starvedHit = 1'b1;
            starvedIdx = IdxW'(i);
         end
         if (reqAccess_i[i] && PriorityMask[i]) begin
            prioHit = 1'b1;
            prioIdx = IdxW'(i);
         end
      end
      for (int k = NumRequesters - 1; k >= 0; k--) begin
         rrCand = IdxW'((int'(rrPointer_q) + k) % NumRequesters);
         if (reqAccess_i[rrCand]) begin
            rrHit = 1'b1;
            rrIdx = rrCand;
         end
      end
   end

   always_comb begin
      grantValid = !reset_i && (starvedHit || prioHit || rrHit);
      winner     = starvedHit ? starvedIdx : (prioHit ? prioIdx : rrIdx);
      winWrite   = reqWrite_i[int'(winner)*DataBusWidth +: DataBusWidth];
      winAddress = reqAddress_i[int'(winner)*AddressBusWidth +: AddressBusWidth];
      winDin     = reqDin_i[int'(winner)*DinW +: DinW];
   end

   // Address and data hold their last driven value when nobody is granted.
   always_comb begin
      reqReady_o     = '0;
      reqDataReady_o = '0;
      if (grantValid) begin
         reqReady_o[winner] = 1'b1;
      end
      if (!reset_i && pendRead_q) begin
         reqDataReady_o[pendIndex_q] = 1'b1;
      end
      reqDout_o    = (!reset_i && pendRead_q) ? memDout_i : doutHold_q;
      memAccess_o  = grantValid;
      memWrite_o   = grantValid ? winWrite : '0;
      memAddress_o = grantValid ? winAddress : addrHold_q;
      memDin_o     = grantValid ? winDin : dinHold_q;
   end

   always_comb begin
      rrPointer_d = rrPointer_q;
      pendRead_d  = 1'b0;
      pendIndex_d = pendIndex_q;
      doutHold_d  = pendRead_q ? memDout_i : doutHold_q;
      addrHold_d  = grantValid ? winAddress : addrHold_q;
      dinHold_d   = grantValid ? winDin : dinHold_q;
      if (grantValid) begin
         rrPointer_d = (int'(winner) == NumRequesters - 1) ? '0 : winner + 1'b1;
         if (winWrite == '0) begin
            pendRead_d  = 1'b1;
            pendIndex_d = winner;
         end
      end
      for (int i = 0; i < NumRequesters; i++) begin
         if (!reqAccess_i[i] || (grantValid && winner == IdxW'(i))) begin
            waitCount_d[i] = '0;
         end else if (waitCount_q[i] == MaxWaitC) begin
            waitCount_d[i] = waitCount_q[i];
         end else begin
            waitCount_d[i] = waitCount_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rrPointer_q <= '0;
         pendRead_q  <= 1'b0;
         pendIndex_q <= '0;
         doutHold_q  <= '0;
         addrHold_q  <= '0;
         dinHold_q   <= '0;
         for (int i = 0; i < NumRequesters; i++) begin
            waitCount_q[i] <= '0;
         end
      end else begin
         rrPointer_q <= rrPointer_d;
         pendRead_q  <= pendRead_d;
         pendIndex_q <= pendIndex_d;
         doutHold_q  <= doutHold_d;
         addrHold_q  <= addrHold_d;
         dinHold_q   <= dinHold_d;
         for (int i = 0; i < NumRequesters; i++) begin
            waitCount_q[i] <= waitCount_d[i];
         end
      end
   end

endmodule

// File: tb/tb_retro_bram_arbiter.sv
// Self-checking bench for retro_bram_arbiter: directed scenarios plus a
// randomized run against a behavioural arbitration and memory model.
module tb_retro_bram_arbiter;

   localparam int N       = 4;
   localparam int AW      = 12;
   localparam int DW      = 1;
   localparam int MaxWait = 7;
   localparam logic [N-1:0] PMask = 4'b0001;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      reqAccess = '0;
   logic [N*DW-1:0]   reqWrite = '0;
   logic [N*AW-1:0]   reqAddress = '0;
   logic [N*8*DW-1:0] reqDin = '0;
   logic [N-1:0]      reqReady, reqDataReady;
   logic [8*DW-1:0]   reqDout;
   logic              memAccess;
   logic [DW-1:0]     memWrite;
   logic [AW-1:0]     memAddress;
   logic [8*DW-1:0]   memDin;
   logic [8*DW-1:0]   memDout = '0;

   retro_bram_arbiter #(
      .NumRequesters(N), .AddressBusWidth(AW), .DataBusWidth(DW),
      .PriorityMask(PMask), .MaxWait(MaxWait)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .reqAccess_i(reqAccess), .reqWrite_i(reqWrite),
      .reqAddress_i(reqAddress), .reqDin_i(reqDin),
      .reqReady_o(reqReady), .reqDataReady_o(reqDataReady), .reqDout_o(reqDout),
      .memAccess_o(memAccess), .memWrite_o(memWrite),
      .memAddress_o(memAddress), .memDin_o(memDin), .memDout_i(memDout)
   );

   always #5 clk = ~clk;

   // Simple single-port BRAM with one cycle read latency.
   logic [8*DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (memAccess) begin
         if (memWrite != '0) begin
            for (int b = 0; b < DW; b++)
               if (memWrite[b]) ram[memAddress][b*8 +: 8] <= memDin[b*8 +: 8];
         end else begin
            memDout <= ram[memAddress];
         end
      end
   end

   // Requester-side stimulus
   bit              tReset;
   bit              tAcc  [N];
   logic [DW-1:0]   tWr   [N];
   logic [AW-1:0]   tAddr [N];
   logic [8*DW-1:0] tDin  [N];

   // Reference model state
   int              rrM;
   int              waitM [N];
   bit              pendM;
   int              pendIdxM;
   logic [8*DW-1:0] pendDataM;
   logic [8*DW-1:0] expMem [0:(1<<AW)-1];

   // Expected outputs for the current cycle
   int              expWin;
   logic [N-1:0]    expReady, expDataReady;
   logic            expAccess;
   logic [DW-1:0]   expWrite;
   logic [AW-1:0]   expAddr;
   logic [8*DW-1:0] expDin, expDout;

   int testsRun = 0;
   int testsFailed = 0;

   // Starved first, then priority, then first requester at or after the pointer.
   function automatic int pickWinner();
      for (int i = 0; i < N; i++) if (tAcc[i] && waitM[i] == MaxWait) return i;
      for (int i = 0; i < N; i++) if (tAcc[i] && PMask[i]) return i;
      for (int k = 0; k < N; k++) if (tAcc[(rrM + k) % N]) return (rrM + k) % N;
      return -1;
   endfunction

   task automatic applyStimulus();
      @(negedge clk);
      reset = tReset;
      for (int i = 0; i < N; i++) begin
         reqAccess[i]               = tAcc[i];
         reqWrite[i*DW +: DW]       = tWr[i];
         reqAddress[i*AW +: AW]     = tAddr[i];
         reqDin[i*8*DW +: 8*DW]     = tDin[i];
      end
      #1;
      expWin       = tReset ? -1 : pickWinner();
      expReady     = '0;
      expAccess    = (expWin >= 0);
      expWrite     = '0;
      expAddr      = '0;
      expDin       = '0;
      if (expWin >= 0) begin
         expReady[expWin] = 1'b1;
         expWrite = tWr[expWin];
         expAddr  = tAddr[expWin];
         expDin   = tDin[expWin];
      end
      expDataReady = '0;
      if (!tReset && pendM) expDataReady[pendIdxM] = 1'b1;
      expDout = pendDataM;
   endtask

   task automatic modelCommit();
      if (tReset) begin
         rrM = 0; pendM = 0; pendIdxM = 0;
         for (int i = 0; i < N; i++) waitM[i] = 0;
      end else begin
         for (int i = 0; i < N; i++)
            waitM[i] = (!tAcc[i] || i == expWin) ? 0 :
                       (waitM[i] < MaxWait ? waitM[i] + 1 : MaxWait);
         pendM = 0;
         if (expWin >= 0) begin
            rrM = (expWin + 1) % N;
            if (tWr[expWin] == '0) begin
               pendM = 1; pendIdxM = expWin; pendDataM = expMem[tAddr[expWin]];
            end else begin
               for (int b = 0; b < DW; b++)
                  if (tWr[expWin][b]) expMem[tAddr[expWin]][b*8 +: 8] = tDin[expWin][b*8 +: 8];
            end
         end
      end
   endtask

   task automatic clearReqs();
      for (int i = 0; i < N; i++) begin
         tAcc[i] = 0; tWr[i] = '0; tAddr[i] = '0; tDin[i] = '0;
      end
   endtask

   task automatic setReq(input int i, input logic [DW-1:0] wr,
                         input logic [AW-1:0] addr, input logic [8*DW-1:0] din);
      tAcc[i] = 1; tWr[i] = wr; tAddr[i] = addr; tDin[i] = din;
   endtask

   task automatic doReset();
      clearReqs();
      tReset = 1;
      applyStimulus();
      modelCommit();
      tReset = 0;
   endtask

   task automatic test_reset();
      tReset = 1;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < N; i++) setReq(i, DW'($urandom_range(0, 1)), AW'($urandom), 8'($urandom));
         applyStimulus();
         testsRun++;
         if (reqReady !== '0 || memAccess !== 1'b0 || reqDataReady !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs cycle %0d: ready=%b access=%b dataReady=%b, want all 0",
                     c, reqReady, memAccess, reqDataReady);
         end
         modelCommit();
      end
      tReset = 0;
      clearReqs();
      applyStimulus();
      testsRun++;
      if (reqReady !== '0 || memAccess !== 1'b0 || memWrite !== '0 || memAddress !== '0 ||
          memDin !== '0 || reqDout !== '0) begin
         testsFailed++;
         $display("[TB] FAIL post_reset_idle: ready=%b acc=%b wr=%b addr=%h din=%h dout=%h, want all 0",
                  reqReady, memAccess, memWrite, memAddress, memDin, reqDout);
      end
      modelCommit();
   endtask

   task automatic test_round_robin();
      int seq [6] = '{1, 2, 3, 1, 2, 3};
      logic [N-1:0] want;
      doReset();
      for (int i = 1; i < N; i++) setReq(i, '0, AW'(12'h010 + i), '0);
      for (int c = 0; c < 6; c++) begin
         applyStimulus();
         want = '0; want[seq[c]] = 1'b1;
         testsRun++;
         if (reqReady !== want) begin
            testsFailed++;
            $display("[TB] FAIL rr_grant cycle %0d: got %b want %b", c, reqReady, want);
         end
         if (c > 0) begin
            want = '0; want[seq[c-1]] = 1'b1;
            testsRun++;
            if (reqDataReady !== want || reqDout !== expMem[AW'(12'h010 + seq[c-1])]) begin
               testsFailed++;
               $display("[TB] FAIL rr_read_return cycle %0d: dataReady=%b dout=%h want %b %h",
                        c, reqDataReady, reqDout, want, expMem[AW'(12'h010 + seq[c-1])]);
            end
         end
         modelCommit();
      end
      clearReqs();
   endtask

   task automatic test_starvation();
      logic [N-1:0] want;
      doReset();
      setReq(0, '0, AW'(12'h040), '0);
      setReq(2, '0, AW'(12'h042), '0);
      for (int c = 0; c < 16; c++) begin
         applyStimulus();
         want = (c % 8 == 7) ? 4'b0100 : 4'b0001;
         testsRun++;
         if (reqReady !== want) begin
            testsFailed++;
            $display("[TB] FAIL starve_grant cycle %0d: got %b want %b", c, reqReady, want);
         end
         modelCommit();
      end
      clearReqs();
   endtask

   task automatic test_write_read();
      doReset();
      setReq(1, 1'b1, 12'h123, 8'hA5);
      applyStimulus();
      testsRun++;
      if (reqReady !== 4'b0010 || memWrite !== 1'b1 || memAddress !== 12'h123 ||
          memDin !== 8'hA5 || reqDataReady !== '0) begin
         testsFailed++;
         $display("[TB] FAIL write_cycle: ready=%b wr=%b addr=%h din=%h dr=%b want 0010 1 123 a5 0000",
                  reqReady, memWrite, memAddress, memDin, reqDataReady);
      end
      modelCommit();
      setReq(1, 1'b0, 12'h123, 8'h00);
      applyStimulus();
      testsRun++;
      if (reqReady !== 4'b0010 || memWrite !== 1'b0 || reqDataReady !== '0) begin
         testsFailed++;
         $display("[TB] FAIL read_grant_after_write: ready=%b wr=%b dr=%b want 0010 0 0000",
                  reqReady, memWrite, reqDataReady);
      end
      modelCommit();
      clearReqs();
      applyStimulus();
      testsRun++;
      if (reqDataReady !== 4'b0010 || reqDout !== 8'hA5) begin
         testsFailed++;
         $display("[TB] FAIL read_back: dr=%b dout=%h want 0010 a5", reqDataReady, reqDout);
      end
      modelCommit();
   endtask

   task automatic test_rr_wrap();
      doReset();
      setReq(1, '0, 12'h020, '0);
      applyStimulus();
      testsRun++;
      if (reqReady !== 4'b0010) begin
         testsFailed++;
         $display("[TB] FAIL wrap_setup: got %b want 0010", reqReady);
      end
      modelCommit();
      setReq(3, '0, 12'h023, '0);
      applyStimulus();
      testsRun++;
      if (reqReady !== 4'b1000 || reqDataReady !== 4'b0010) begin
         testsFailed++;
         $display("[TB] FAIL wrap_first: ready=%b dr=%b want 1000 0010", reqReady, reqDataReady);
      end
      modelCommit();
      tAcc[3] = 0;
      applyStimulus();
      testsRun++;
      if (reqReady !== 4'b0010 || reqDataReady !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL wrap_second: ready=%b dr=%b want 0010 1000", reqReady, reqDataReady);
      end
      modelCommit();
      clearReqs();
   endtask

   task automatic test_reset_mid_read();
      doReset();
      setReq(2, '0, 12'h033, '0);
      applyStimulus();
      testsRun++;
      if (reqReady !== 4'b0100) begin
         testsFailed++;
         $display("[TB] FAIL midread_grant: got %b want 0100", reqReady);
      end
      modelCommit();
      clearReqs();
      tReset = 1;
      applyStimulus();
      testsRun++;
      if (reqDataReady !== '0) begin
         testsFailed++;
         $display("[TB] FAIL midread_during_reset: dr=%b want 0000", reqDataReady);
      end
      modelCommit();
      tReset = 0;
      applyStimulus();
      testsRun++;
      if (reqDataReady !== '0 || reqReady !== '0 || memAccess !== 1'b0 ||
          memAddress !== '0 || reqDout !== '0) begin
         testsFailed++;
         $display("[TB] FAIL midread_after_reset: dr=%b ready=%b acc=%b addr=%h dout=%h want zeros",
                  reqDataReady, reqReady, memAccess, memAddress, reqDout);
      end
      modelCommit();
      setReq(1, '0, 12'h001, '0);
      setReq(3, '0, 12'h003, '0);
      applyStimulus();
      testsRun++;
      if (reqReady !== 4'b0010) begin
         testsFailed++;
         $display("[TB] FAIL midread_pointer_cleared: got %b want 0010", reqReady);
      end
      modelCommit();
      clearReqs();
   endtask

   task automatic test_drop_wait();
      logic [N-1:0] want;
      doReset();
      setReq(0, '0, 12'h050, '0);
      setReq(1, '0, 12'h051, '0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus();
         testsRun++;
         if (reqReady !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL drop_denied cycle %0d: got %b want 0001", c, reqReady);
         end
         modelCommit();
      end
      tAcc[1] = 0;
      applyStimulus();
      testsRun++;
      if (reqReady !== 4'b0001) begin
         testsFailed++;
         $display("[TB] FAIL drop_no_late_grant: got %b want 0001", reqReady);
      end
      modelCommit();
      tAcc[1] = 1;
      for (int c = 0; c < 8; c++) begin
         applyStimulus();
         want = (c == 7) ? 4'b0010 : 4'b0001;
         testsRun++;
         if (reqReady !== want) begin
            testsFailed++;
            $display("[TB] FAIL drop_wait_restart cycle %0d: got %b want %b", c, reqReady, want);
         end
         modelCommit();
      end
      clearReqs();
   endtask

   task automatic test_random();
      doReset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!tAcc[i]) begin
               if ($urandom_range(0, 1) == 1)
                  setReq(i, DW'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 8'($urandom));
            end else if ($urandom_range(0, 9) == 0) begin
               tAcc[i] = 0;
            end
         end
         tReset = ($urandom_range(0, 49) == 0);
         applyStimulus();
         testsRun++;
         if (reqReady !== expReady || memAccess !== expAccess || memWrite !== expWrite) begin
            testsFailed++;
            $display("[TB] FAIL rand_grant cycle %0d: ready=%b acc=%b wr=%b want %b %b %b",
                     c, reqReady, memAccess, memWrite, expReady, expAccess, expWrite);
         end
         if (expAccess) begin
            testsRun++;
            if (memAddress !== expAddr || memDin !== expDin) begin
               testsFailed++;
               $display("[TB] FAIL rand_fields cycle %0d: addr=%h din=%h want %h %h",
                        c, memAddress, memDin, expAddr, expDin);
            end
         end
         testsRun++;
         if (reqDataReady !== expDataReady ||
             (expDataReady != '0 && reqDout !== expDout)) begin
            testsFailed++;
            $display("[TB] FAIL rand_read cycle %0d: dr=%b dout=%h want %b %h",
                     c, reqDataReady, reqDout, expDataReady, expDout);
         end
         modelCommit();
         if (expWin >= 0) tAcc[expWin] = 0;
      end
      tReset = 0;
      clearReqs();
   endtask

   initial begin
      for (int a = 0; a < (1 << AW); a++) begin
         ram[a]    = (8*DW)'(a * 7 + 3);
         expMem[a] = (8*DW)'(a * 7 + 3);
      end
      rrM = 0; pendM = 0; pendIdxM = 0; pendDataM = '0;
      for (int i = 0; i < N; i++) waitM[i] = 0;
      clearReqs();
      tReset = 1;
      test_reset();
      test_round_robin();
      test_starvation();
      test_write_read();
      test_rr_wrap();
      test_reset_mid_read();
      test_drop_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
